// File: rtl/wbu_if.sv
`timescale 1ns/1ps
// Retire handshake from EXU, load-data return, and the registered write port
// that WBU drives back into the decode-stage register file.
interface wbu_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rd;
   logic        in_R_wen;
   logic [3:0]  in_csr_wen;
   logic [31:0] in_alu_result;
   logic [31:0] in_csr_old;
   logic [2:0]  in_funct3;
   logic        in_mem_ren;
   logic        in_jump;
   logic        in_ecall;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  rd;
   logic [31:0] rd_value;
   logic        R_wen;
   logic [3:0]  csr_wen;
   logic [31:0] csrd;
   logic        commit;
   logic [31:0] commit_pc;
   logic        bus_err;

   modport master (
      output in_valid, in_pc, in_rd, in_R_wen, in_csr_wen, in_alu_result, in_csr_old,
             in_funct3, in_mem_ren, in_jump, in_ecall, mem_rvalid, mem_rdata,
      input  in_ready, rd, rd_value, R_wen, csr_wen, csrd, commit, commit_pc, bus_err
   );

   modport slave (
      input  in_valid, in_pc, in_rd, in_R_wen, in_csr_wen, in_alu_result, in_csr_old,
             in_funct3, in_mem_ren, in_jump, in_ecall, mem_rvalid, mem_rdata,
      output in_ready, rd, rd_value, R_wen, csr_wen, csrd, commit, commit_pc, bus_err
   );
endinterface

// File: rtl/wbu.sv
`timescale 1ns/1ps
// Write-back stage: retires one EXU instruction per handshake, waits on load data
// with a bounded timeout, and drives one-cycle registered GPR/CSR write pulses.
module wbu #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic rst_n,
   wbu_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        r_wen;
      logic [3:0]  csr_wen;
      logic [31:0] alu_result;
      logic [31:0] csr_old;
      logic [2:0]  funct3;
      logic        mem_ren;
      logic        jump;
      logic        ecall;
   } instr_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   instr_t           instr_reg;
   instr_t           incoming;
   instr_t           src;
   logic             accept;
   logic             retire;
   logic             timeout;

   logic [7:0]       byte_lane [4];
   logic [15:0]      half_lane [2];
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_value;

   logic             wb_r_wen;
   logic [3:0]       wb_csr_wen;
   logic [31:0]      wb_rd_value;
   logic             wb_rd_upd;
   logic [31:0]      wb_csrd;
   logic             wb_csrd_upd;

   logic [4:0]       rd_reg;
   logic [31:0]      rd_value_reg;
   logic             r_wen_reg;
   logic [3:0]       csr_wen_reg;
   logic [31:0]      csrd_reg;
   logic             commit_reg;
   logic [31:0]      commit_pc_reg;
   logic             bus_err_reg;

   always_comb begin
      incoming            = '0;
      incoming.pc         = bus.in_pc;
      incoming.rd         = bus.in_rd;
      incoming.r_wen      = bus.in_R_wen;
      incoming.csr_wen    = bus.in_csr_wen;
      incoming.alu_result = bus.in_alu_result;
      incoming.csr_old    = bus.in_csr_old;
      incoming.funct3     = bus.in_funct3;
      incoming.mem_ren    = bus.in_mem_ren;
      incoming.jump       = bus.in_jump;
      incoming.ecall      = bus.in_ecall;
   end

   // Non-loads retire straight from the inputs; loads retire from the latched copy.
   assign src = (state_reg == IDLE) ? incoming : instr_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      retire     = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: begin
            accept = bus.in_valid;
            // ecall takes priority over every other kind, so it never waits for data.
            if (accept) begin
               if (incoming.mem_ren && !incoming.ecall) begin
                  state_next = WAIT_MEM;
                  cnt_next   = '0;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            if (bus.mem_rvalid) begin
               retire     = 1'b1;
               state_next = IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_reg <= '0;
      end else if (accept) begin
         instr_reg <= incoming;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = bus.mem_rdata[8*gi +: 8];
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_lane[gi] = bus.mem_rdata[16*gi +: 16];
   end

   always_comb begin
      ld_byte = byte_lane[src.alu_result[1:0]];
      ld_half = half_lane[src.alu_result[1]];
      case (src.funct3)
         3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_value = {24'd0, ld_byte};
         3'b101:  ld_value = {16'd0, ld_half};
         default: ld_value = bus.mem_rdata;
      endcase
   end

   always_comb begin
      wb_r_wen    = 1'b0;
      wb_csr_wen  = 4'b0000;
      wb_rd_value = src.alu_result;
      wb_rd_upd   = 1'b1;
      wb_csrd     = src.alu_result;
      wb_csrd_upd = 1'b0;
      if (src.ecall) begin
         // mcause is written by the regfile itself; only mepc needs our data.
         wb_csr_wen  = 4'b0011;
         wb_csrd     = src.pc;
         wb_csrd_upd = 1'b1;
         wb_rd_upd   = 1'b0;
      end else begin
         wb_r_wen = src.r_wen && (src.rd != 5'd0);
         if (src.mem_ren) begin
            wb_rd_value = ld_value;
         end else if (src.csr_wen != 4'b0000) begin
            wb_rd_value = src.csr_old;
            wb_csrd     = src.alu_result;
            wb_csrd_upd = 1'b1;
            wb_csr_wen  = src.csr_wen;
         end else if (src.jump) begin
            wb_rd_value = src.pc + 32'd4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_reg        <= '0;
         rd_value_reg  <= '0;
         r_wen_reg     <= 1'b0;
         csr_wen_reg   <= '0;
         csrd_reg      <= '0;
         commit_reg    <= 1'b0;
         commit_pc_reg <= '0;
         bus_err_reg   <= 1'b0;
      end else begin
         r_wen_reg   <= 1'b0;
         csr_wen_reg <= '0;
         commit_reg  <= 1'b0;
         bus_err_reg <= 1'b0;
         if (retire) begin
            commit_reg    <= 1'b1;
            commit_pc_reg <= src.pc;
            rd_reg        <= src.rd;
            r_wen_reg     <= wb_r_wen;
            csr_wen_reg   <= wb_csr_wen;
            if (wb_rd_upd) begin
               rd_value_reg <= wb_rd_value;
            end
            if (wb_csrd_upd) begin
               csrd_reg <= wb_csrd;
            end
         end else if (timeout) begin
            commit_reg    <= 1'b1;
            bus_err_reg   <= 1'b1;
            commit_pc_reg <= instr_reg.pc;
            rd_value_reg  <= '0;
         end
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.rd        = rd_reg;
   assign bus.rd_value  = rd_value_reg;
   assign bus.R_wen     = r_wen_reg;
   assign bus.csr_wen   = csr_wen_reg;
   assign bus.csrd      = csrd_reg;
   assign bus.commit    = commit_reg;
   assign bus.commit_pc = commit_pc_reg;
   assign bus.bus_err   = bus_err_reg;

endmodule
